// File: rtl/osoc86_ram_ctrl.sv
// Byte-array RAM controller for the osoc86 bus: single byte/word reads and writes,
// 32-bit burst reads, optional wait states and illegal-request flagging.
module osoc86_ram_ctrl #(
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned MEM_AW      = 16,
  parameter int unsigned BURST_LEN   = 8,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic [1:0]        iRamRW,
  input  logic              iRamBW,
  input  logic [1:0]        iRamBurst,
  input  logic [ADDR_W-1:0] iRamAdr,
  input  logic [15:0]       iRamData,
  output logic              oRamAck,
  output logic [31:0]       oRamData,
  output logic              oBusy,
  output logic              oErr
);

  localparam int unsigned BEAT_W = $clog2(BURST_LEN + 1);

  typedef enum logic [2:0] {IDLE, WAIT, SINGLE, BURST, GAP} state_t;

  state_t            r_state;
  logic [7:0]        r_mem [2**MEM_AW];
  logic [MEM_AW-1:0] r_adr;
  logic [15:0]       r_data;
  logic              r_bw;
  logic              r_wr;
  logic              r_bst;
  logic [3:0]        r_wait;
  logic [BEAT_W-1:0] r_beat;
  logic              r_ack;
  logic [31:0]       r_rdata;
  logic              r_err;

  logic              w_req_wr;
  logic              w_req_bst;
  logic              w_req_rd;
  logic              w_illegal;
  logic [MEM_AW-1:0] w_a0;
  logic [MEM_AW-1:0] w_a1;
  logic [MEM_AW-1:0] w_a2;
  logic [MEM_AW-1:0] w_a3;

  assign w_req_wr  = iRamRW[0];
  assign w_req_bst = (iRamBurst == 2'd2);
  assign w_req_rd  = iRamRW[1];
  assign w_illegal = (iRamRW == 2'b11) || (w_req_bst && (iRamRW != 2'b00));

  // Byte indices wrap naturally in MEM_AW-bit arithmetic; r_beat is zero for singles.
  assign w_a0 = r_adr + MEM_AW'({r_beat, 2'b00});
  assign w_a1 = w_a0 + MEM_AW'(1);
  assign w_a2 = w_a0 + MEM_AW'(2);
  assign w_a3 = w_a0 + MEM_AW'(3);

  generate
    if (ADDR_W > MEM_AW) begin : g_hi
      logic w_unused_hi;
      assign w_unused_hi = ^iRamAdr[ADDR_W-1:MEM_AW];
    end
  endgenerate

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state <= IDLE;
      r_adr   <= '0;
      r_data  <= '0;
      r_bw    <= 1'b0;
      r_wr    <= 1'b0;
      r_bst   <= 1'b0;
      r_wait  <= '0;
      r_beat  <= '0;
      r_ack   <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req_wr || w_req_bst || w_req_rd) begin
            r_adr  <= iRamAdr[MEM_AW-1:0];
            r_data <= iRamData;
            r_bw   <= iRamBW;
            r_wr   <= w_req_wr;
            r_bst  <= !w_req_wr && w_req_bst;
            r_wait <= 4'(WAIT_STATES);
            r_beat <= '0;
            r_err  <= w_illegal;
            if (WAIT_STATES != 0)                r_state <= WAIT;
            else if (!w_req_wr && w_req_bst)     r_state <= BURST;
            else                                 r_state <= SINGLE;
          end
        end
        WAIT: begin
          r_wait <= r_wait - 4'd1;
          if (r_wait == 4'd1) r_state <= r_bst ? BURST : SINGLE;
        end
        SINGLE: begin
          r_ack   <= 1'b1;
          r_state <= IDLE;
          if (!r_wr) r_rdata <= {16'd0, (r_bw ? r_mem[w_a1] : 8'd0), r_mem[w_a0]};
        end
        BURST: begin
          // Beats are registered one edge after their state cycle, so the cycle
          // after the final beat is still BURST and GAP shows ack low.
          if (r_beat == BEAT_W'(BURST_LEN)) begin
            r_state <= GAP;
          end else begin
            r_ack   <= 1'b1;
            r_rdata <= {r_mem[w_a3], r_mem[w_a2], r_mem[w_a1], r_mem[w_a0]};
            r_beat  <= r_beat + BEAT_W'(1);
          end
        end
        GAP: begin
          r_beat  <= '0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Memory array has no reset so its contents survive iRst.
  always_ff @(posedge iClk) begin
    if (r_state == SINGLE && r_wr) begin
      r_mem[w_a0] <= r_data[7:0];
      if (r_bw) r_mem[w_a1] <= r_data[15:8];
    end
  end

  assign oRamAck  = r_ack;
  assign oRamData = r_rdata;
  assign oBusy    = (r_state != IDLE);
  assign oErr     = r_err;

endmodule

// File: tb/tb_osoc86_ram_ctrl.sv
// Directed bench for osoc86_ram_ctrl: one instance with no wait states, one with three.
module tb_osoc86_ram_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  logic [1:0]  rw  [2];
  logic        bw  [2];
  logic [1:0]  bst [2];
  logic [19:0] adr [2];
  logic [15:0] wd  [2];
  logic        ack [2];
  logic [31:0] rd  [2];
  logic        busy[2];
  logic        err [2];

  int unsigned n_checks = 0;
  int unsigned n_errs   = 0;

  osoc86_ram_ctrl #(.ADDR_W(20), .MEM_AW(16), .BURST_LEN(8), .WAIT_STATES(0)) u_dut0 (
    .iClk(clk), .iRst(rst[0]), .iRamRW(rw[0]), .iRamBW(bw[0]), .iRamBurst(bst[0]),
    .iRamAdr(adr[0]), .iRamData(wd[0]), .oRamAck(ack[0]), .oRamData(rd[0]),
    .oBusy(busy[0]), .oErr(err[0])
  );

  osoc86_ram_ctrl #(.ADDR_W(20), .MEM_AW(16), .BURST_LEN(8), .WAIT_STATES(3)) u_dut3 (
    .iClk(clk), .iRst(rst[1]), .iRamRW(rw[1]), .iRamBW(bw[1]), .iRamBurst(bst[1]),
    .iRamAdr(adr[1]), .iRamData(wd[1]), .oRamAck(ack[1]), .oRamData(rd[1]),
    .oBusy(busy[1]), .oErr(err[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns edges from sampling to ack (0 = timed out).
  task automatic access(input int sel, input logic [1:0] rwv, input logic bwv,
                        input logic [19:0] a, input logic [15:0] d,
                        output int lat, output logic [31:0] q, output int errs);
    rw[sel] = rwv; bw[sel] = bwv; bst[sel] = 2'd0; adr[sel] = a; wd[sel] = d;
    lat = 0; errs = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); @(negedge clk);
      if (err[sel]) errs++;
      if (ack[sel]) begin lat = n; break; end
    end
    q = rd[sel];
    rw[sel] = 2'd0;
  endtask

  task automatic burst(input int sel, input logic [1:0] rwv, input logic [19:0] a,
                       input int nb, input logic [31:0] base, input int exp_errs);
    int lat;
    int errs;
    rw[sel] = rwv; bw[sel] = 1'b0; bst[sel] = 2'd2; adr[sel] = a; wd[sel] = 16'h0;
    lat = 0; errs = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); @(negedge clk);
      if (err[sel]) errs++;
      if (ack[sel]) begin lat = n; break; end
    end
    rw[sel] = 2'd0; bst[sel] = 2'd0;
    check("burst_lat", lat, 2);
    check("burst_err", errs, exp_errs);
    for (int k = 0; k < nb; k++) begin
      if (k > 0) begin @(posedge clk); @(negedge clk); end
      check($sformatf("beat%0d_ack", k), ack[sel], 1);
      check($sformatf("beat%0d_data", k), rd[sel], base + 32'h04040404 * k);
    end
    if (nb == 8) begin
      @(posedge clk); @(negedge clk);
      check("gap_ack", ack[sel], 0);
      check("gap_busy", busy[sel], 1);
      @(posedge clk); @(negedge clk);
      check("post_gap_busy", busy[sel], 0);
    end
  endtask

  int lat;
  int errs;
  logic [31:0] q;

  initial begin
    for (int s = 0; s < 2; s++) begin
      rst[s] = 1'b1; rw[s] = 2'd0; bw[s] = 1'b0; bst[s] = 2'd0; adr[s] = '0; wd[s] = '0;
    end
    @(negedge clk); @(negedge clk);
    check("rst_ack", ack[0], 0);
    check("rst_data", rd[0], 32'h0);
    check("rst_busy", busy[0], 0);
    check("rst_err", err[0], 0);
    check("rst3_busy", busy[1], 0);
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);

    access(0, 2'b01, 1'b1, 20'h00010, 16'hBEEF, lat, q, errs);
    check("wr_lat", lat, 2);
    access(0, 2'b10, 1'b1, 20'h00010, 16'h0, lat, q, errs);
    check("rd_lat", lat, 2);
    check("rd_word", q, 32'h0000BEEF);
    access(0, 2'b10, 1'b0, 20'h00011, 16'h0, lat, q, errs);
    check("rd_byte_hi", q, 32'h000000BE);

    access(0, 2'b01, 1'b1, 20'h00021, 16'h7766, lat, q, errs);
    access(0, 2'b01, 1'b0, 20'h00021, 16'hAB5A, lat, q, errs);
    check("wr_holds_data", q, 32'h000000BE);
    check("wr_idle_busy", busy[0], 0);
    access(0, 2'b10, 1'b0, 20'h00021, 16'h0, lat, q, errs);
    check("rd_byte", q, 32'h0000005A);
    access(0, 2'b10, 1'b1, 20'h00021, 16'h0, lat, q, errs);
    check("byte_neighbour", q, 32'h0000775A);

    for (int k = 0; k < 16; k++)
      access(0, 2'b01, 1'b1, 20'(2 * k), 16'((2 * k + 1) * 256 + 2 * k), lat, q, errs);
    burst(0, 2'b00, 20'h00000, 8, 32'h03020100, 0);

    burst(0, 2'b00, 20'h00000, 4, 32'h03020100, 0);
    rst[0] = 1'b1;
    #1;
    check("abort_ack", ack[0], 0);
    check("abort_busy", busy[0], 0);
    check("abort_data", rd[0], 32'h0);
    @(negedge clk);
    rst[0] = 1'b0;
    @(negedge clk);
    burst(0, 2'b10, 20'h00000, 8, 32'h03020100, 1);

    access(0, 2'b01, 1'b1, 20'h0FFFF, 16'h1234, lat, q, errs);
    access(0, 2'b10, 1'b0, 20'h0FFFF, 16'h0, lat, q, errs);
    check("wrap_lo", q, 32'h00000034);
    access(0, 2'b10, 1'b0, 20'h10000, 16'h0, lat, q, errs);
    check("wrap_hi", q, 32'h00000012);

    access(1, 2'b11, 1'b1, 20'h00040, 16'hA55A, lat, q, errs);
    check("ws3_wr_lat", lat, 5);
    check("ws3_err_pulse", errs, 1);
    access(1, 2'b10, 1'b1, 20'h00040, 16'h0, lat, q, errs);
    check("ws3_rd_lat", lat, 5);
    check("ws3_rd_err", errs, 0);
    check("ws3_rd_data", q, 32'h0000A55A);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
